// File: rtl/rmac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rmac_pkg: shared FSM type and Q12.20 sign-magnitude constants.  Rev 1.0
// ---------------------------------------------------------------------------
package rmac_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } rmac_state_e;

  localparam int RMAC_S        = 8;
  localparam int RMAC_N        = 32;
  localparam int RMAC_FRACBITS = 20;

  localparam logic [RMAC_N-1:0] Q_ONE = RMAC_N'(1) << RMAC_FRACBITS;
  localparam int SIGN_BIT = RMAC_N - 1;

endpackage
`default_nettype wire

// File: rtl/rmac_opbuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rmac_opbuf: S-entry weight/activation register file, 1 write, 1 comb read.
// Rev 1.0
// ---------------------------------------------------------------------------
module rmac_opbuf #(
  parameter int S = 8,
  parameter int n = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(S)-1:0] waddr,
  input  logic [n-1:0]         wdata_w,
  input  logic [n-1:0]         wdata_x,
  input  logic [$clog2(S)-1:0] raddr,
  output logic [n-1:0]         rdata_w,
  output logic [n-1:0]         rdata_x
);

  // Contents are deliberately unreset: every entry is rewritten before use.
  logic [n-1:0] mem_w_q [S];
  logic [n-1:0] mem_x_q [S];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_w_q[waddr] <= wdata_w;
      mem_x_q[waddr] <= wdata_x;
    end
  end

  assign rdata_w = mem_w_q[raddr];
  assign rdata_x = mem_x_q[raddr];

endmodule
`default_nettype wire

// File: rtl/rmac_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rmac_sequencer: buffers S operand pairs, streams them into one rmac lane and
// returns the MAC's registered sum over a valid/ready result port.  Rev 1.0
// ---------------------------------------------------------------------------
module rmac_sequencer
  import rmac_pkg::*;
#(
  parameter int S        = RMAC_S,
  parameter int n        = RMAC_N,
  parameter int intbits  = 12,
  parameter int fracbits = RMAC_FRACBITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [n-1:0] ld_w,
  input  logic [n-1:0] ld_x,
  output logic [n-1:0] mac_w,
  output logic [n-1:0] mac_x,
  output logic         mac_en_s2,
  output logic         mac_local_en,
  output logic         mac_reset,
  input  logic [n-1:0] mac_sum,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [n-1:0] res_data,
  output logic         busy
);

  localparam int            IW       = $clog2(S);
  localparam logic [IW-1:0] IDX_LAST = IW'(S - 1);

  // The MAC latches its sum at a fixed count of 8, so no other length works.
  generate
    if (S != RMAC_S) begin : g_bad_s
      $error("rmac_sequencer: S must equal the MAC accumulation length 8");
    end
    if (intbits + fracbits != n) begin : g_bad_q
      $error("rmac_sequencer: intbits + fracbits must equal n");
    end
  endgenerate

  rmac_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wait_q, wait_d;
  logic          res_valid_q, res_valid_d;
  logic [n-1:0]  res_data_q, res_data_d;
  logic          buf_we;
  logic [n-1:0]  buf_rd_w, buf_rd_x;

  rmac_opbuf #(
    .S (S),
    .n (n)
  ) u_opbuf (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (idx_q),
    .wdata_w (ld_w),
    .wdata_x (ld_x),
    .raddr   (idx_q),
    .rdata_w (buf_rd_w),
    .rdata_x (buf_rd_x)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      wait_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    buf_we       = 1'b0;
    ld_ready     = 1'b0;
    mac_w        = '0;
    mac_x        = '0;
    mac_en_s2    = 1'b0;
    mac_local_en = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        idx_d   = '0;
        wait_d  = 1'b0;
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // No pair is accepted in a cycle that is about to be reset away.
        ld_ready = !reset;
        buf_we   = ld_valid && ld_ready;
        if (buf_we) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STREAM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_STREAM: begin
        mac_w        = buf_rd_w;
        mac_x        = buf_rd_x;
        mac_en_s2    = 1'b1;
        mac_local_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          wait_d  = 1'b0;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_WAIT: begin
        // Two cycles: MAC psum settles, then MAC registers its ReLU'd sum.
        wait_d = ~wait_q;
        if (wait_q) begin
          res_data_d  = mac_sum;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign mac_reset = reset || (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_LOAD);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
`default_nettype wire

// File: doc/rmac_sequencer.md
# rmac_sequencer

Operand sequencer and result collector for one `rmac` accumulator lane in the FT TwoNeuron datapath. It accepts S weight/activation pairs over a valid/ready load port into an internal buffer. It then clears the MAC, streams the pairs into it, waits for the MAC's registered sum, and presents that sum on a valid/ready result port. Data is 32-bit sign-magnitude Q12.20 and passes through unmodified; ReLU is done by the MAC.

## Interface
- `S`, 8, pairs per dot product; must equal the MAC accumulation length (MAC latches at count 8, so only 8 is legal; elaboration error otherwise)
- `n`, 32, data width
- `intbits`, 12, integer bits (documentation and test constants only)
- `fracbits`, 20, fraction bits (documentation and test constants only)

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `ld_valid`  in  1  load pair offered
- `ld_ready`  out  1  sequencer accepts a pair
- `ld_w`  in  n  weight, sign-magnitude
- `ld_x`  in  n  activation, sign-magnitude
- `mac_w`  out  n  to MAC `W`
- `mac_x`  out  n  to MAC `X`
- `mac_en_s2`  out  1  to MAC `en_s2`
- `mac_local_en`  out  1  to MAC `local_en`
- `mac_reset`  out  1  to MAC `reset`
- `mac_sum`  in  n  from MAC `sum`
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  n  captured dot product, ReLU'd
- `busy`  out  1  state is not LOAD

## Operation
- FSM states: CLEAR, LOAD, STREAM, WAIT, HOLD. `reset` forces CLEAR.
- CLEAR: lasts 1 cycle, `mac_reset`=1, index cleared, then LOAD.
- LOAD:
  - `ld_ready`=1.
  - Each cycle with `ld_valid && ld_ready` writes the pair to entry `idx` and increments `idx`.
  - Accepting entry S-1 moves to STREAM with `idx`=0.
  - `ld_valid` gaps are allowed.
- STREAM:
  - Exactly S cycles.
  - `mac_w`/`mac_x` = buffer[`idx`]; `mac_en_s2` and `mac_local_en` = 1.
  - `idx` increments each cycle; after S-1, go to WAIT.
- WAIT:
  - 2 cycles, counted by a 1-bit counter.
  - MAC enables are 0.
  - At the end of the second cycle, register `mac_sum` into `res_data`, set `res_valid`, go to HOLD.
- HOLD:
  - `res_valid`=1; `res_data` is stable.
  - On `res_valid && res_ready`, clear `res_valid` and go to CLEAR.
- `mac_reset` = `reset` OR (state==CLEAR), decoded from the state register.
- Outside STREAM, `mac_w`/`mac_x` = 0 and both enables = 0.
- Reset values: `ld_ready`=0, `res_valid`=0, `res_data`=0, `mac_*` data/enables=0, `mac_reset`=1, `busy`=1.
- Boundary behaviour:
  - `ld_valid` in any non-LOAD state is ignored; `ld_ready` is 0 there.
  - `reset` mid-STREAM or mid-WAIT aborts the job: the result is discarded, the MAC is cleared, and the buffer contents are don't-care.
  - `res_ready` held high with no result has no effect.
  - No overlap: the next load starts only after the result is consumed.

## Timing
- `reset` deasserted at edge 0 → CLEAR during cycle 0 → LOAD from cycle 1.
- Last load accepted at edge T → STREAM occupies cycles T..T+S-1.
- The MAC's `psum` is final at edge T+S; MAC `sum` is updated at edge T+S+1.
- `res_data` is captured and `res_valid` rises at edge T+S+2 (S+2 cycles after the last accept).
- Handshake completes at edge H → CLEAR in cycle H → `ld_ready` high from edge H+1.
- Minimum period per job with no stalls: S load + S + 2 + 1 HOLD + 1 CLEAR = 2S+4 cycles.

## Structure
- Shared package `rmac_pkg`:
  - FSM state enum
  - `RMAC_S`=8
  - Q-format constants: `Q_ONE` = 1<<fracbits, `SIGN_BIT` = n-1
- Sub-module `rmac_opbuf`: S-entry × 2n register file with one write port (`we`, `waddr`, `wdata_w`, `wdata_x`) and one combinational read port (`raddr`). No reset on contents.
- Testbench instantiates `rmac_sequencer` and `rmac` together.

## Test plan
- All pairs W=0x0010_0000 (1.0), X=0x0010_0000 → `res_data`=0x0080_0000 (8.0); `res_valid` at last accept + 10 cycles.
- W=1.0; X alternating 0x0020_0000 (+2.0) and 0x8010_0000 (−1.0) → 0x0040_0000 (4.0).
- W=0x8010_0000 (−1.0), X=1.0 for all pairs → MAC ReLU gives `res_data`=0x0000_0000 with `res_valid`=1.
- Back-to-back jobs with `res_ready` low for 10 cycles:
  - `res_data` stable and `ld_ready`=0 throughout the stall
  - after `res_ready` goes high, `mac_reset` pulses for exactly 1 cycle, then `ld_ready` rises
  - second job is unaffected by the first: 8.0 then 4.0
- `ld_valid` toggling 1/0 every cycle during LOAD → exactly 8 pairs stored in order; result matches the no-gap case.
- `reset` asserted for 1 cycle in STREAM cycle 3:
  - outputs return to reset values; `mac_reset`=1; the aborted job produces no `res_valid`
  - a fresh all-1.0 job afterwards yields 0x0080_0000
